udp_tx_arbiter: RTL and testbench

- Shares the single UDP send port of the Ethernet UDP engine (valid/ready, data bus, length) among NUM_REQ independent requesters.
- Round-robin grant; the winner's payload and length are captured into a holding register, presented downstream until accepted, then an inter-packet gap is enforced.
- Sits between user logic and the UDP engine in the rgmii_clk domain.

---
 rtl/udp_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 36 +++
 rtl/udp_tx_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP transmit arbiters.
// Holds the arbiter FSM encoding, the requester-count ceiling and the
// width of a requester index.
package udp_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - highest-priority index for this pick
//   winner  - first requesting index at or after ptr (modulo NUM_REQ)
//   any_req - at least one request bit is set
module rr_pick
  import udp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_pad;

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    req_pad = MAX_REQ'(req);
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      idx = ID_W'((int'(ptr) + off) % int'(NUM_REQ));
      if (req_pad[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter sharing the UDP engine send port among NUM_REQ
// requesters. The winning payload/length is captured, held downstream until
// accepted, then GAP_CYCLES idle cycles are enforced before the next grant.
// Optional build macro UDP_TX_ARB_STATS_EN adds per-requester packet counters
// (pkt_cnt) and a saturating drop counter (drop_cnt).
// Ports:
//   rgmii_clk, rst          - clock, synchronous active-high reset
//   req_valid/ready         - per-requester request / one-cycle capture strobe
//   req_data/req_len        - flattened payloads and lengths (slice i = req i)
//   udp_send_data_*         - held packet towards the UDP engine
//   grant_id                - requester of the packet held or last sent
//   len_err                 - pulse when a request is dropped for its length
//   busy                    - high while sending or in the gap
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 961,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned MAX_LEN    = 120,
  parameter int unsigned GAP_CYCLES = 12
) (
  input  logic                      rgmii_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic                      udp_send_data_valid,
  input  logic                      udp_send_data_ready,
  output logic [DATA_W-1:0]         udp_send_data,
  output logic [LEN_W-1:0]          udp_send_data_length,
  output logic [ID_W-1:0]           grant_id,
  output logic                      len_err,
  output logic                      busy
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     pkt_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic                 len_err_q, len_err_d;
  logic                 busy_q, busy_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [DATA_W-1:0]    data_arr [MAX_REQ];
  logic [LEN_W-1:0]     len_arr  [MAX_REQ];
  logic [NUM_REQ-1:0]   req_eff_c;
  logic [ID_W-1:0]      winner_c;
  logic                 any_req_c;
  logic [LEN_W-1:0]     sel_len_c;
  logic                 len_ok_c;
  logic                 accept_c;

  // Unflatten request buses; unused slots read as zero.
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
      assign len_arr[gi]  = req_len[gi*LEN_W +: LEN_W];
    end else begin : g_pad
      assign data_arr[gi] = '0;
      assign len_arr[gi]  = '0;
    end
  end

  // A requester still showing valid during its own strobe cycle is not re-picked.
  assign req_eff_c = req_valid & ~req_ready_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (req_eff_c),
    .ptr     (ptr_q),
    .winner  (winner_c),
    .any_req (any_req_c)
  );

  assign sel_len_c = len_arr[winner_c];
  assign len_ok_c  = (sel_len_c != '0) && (sel_len_c <= LEN_W'(MAX_LEN));
  assign accept_c  = (state_q == ST_SEND) && udp_send_data_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_ready_d = '0;
    valid_d     = valid_q;
    data_d      = data_q;
    len_d       = len_q;
    grant_d     = grant_q;
    len_err_d   = 1'b0;
    gap_cnt_d   = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (any_req_c) begin
          req_ready_d = NUM_REQ'(1) << winner_c;
          grant_d     = winner_c;
          ptr_d       = (winner_c == ID_W'(NUM_REQ - 1)) ? '0 : winner_c + ID_W'(1);
          if (len_ok_c) begin
            data_d  = data_arr[winner_c];
            len_d   = sel_len_c;
            valid_d = 1'b1;
            state_d = ST_SEND;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (accept_c) begin
          valid_d   = 1'b0;
          gap_cnt_d = GAP_W'(GAP_LOAD);
          state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      req_ready_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      len_q       <= '0;
      grant_q     <= '0;
      len_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      len_q       <= len_d;
      grant_q     <= grant_d;
      len_err_q   <= len_err_d;
      busy_q      <= busy_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign req_ready            = req_ready_q;
  assign udp_send_data_valid  = valid_q;
  assign udp_send_data        = data_q;
  assign udp_send_data_length = len_q;
  assign grant_id             = grant_q;
  assign len_err              = len_err_q;
  assign busy                 = busy_q;

`ifdef UDP_TX_ARB_STATS_EN
  logic [15:0] pkt_cnt_q [MAX_REQ];
  logic [15:0] drop_cnt_q;

  // Packet counters wrap; drop counter saturates.
  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_REQ); i++) begin
        pkt_cnt_q[i] <= '0;
      end
      drop_cnt_q <= '0;
    end else begin
      if (accept_c) begin
        pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
      end
      if (len_err_d && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pkt_cnt
    assign pkt_cnt[gi*16 +: 16] = pkt_cnt_q[gi];
  end
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed self-checking bench for udp_tx_arbiter (default parameters).
module tb_udp_tx_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 961;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned GAP     = 12;

  logic                      rgmii_clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ*LEN_W-1:0]  req_len = '0;
  logic                      udp_send_data_valid;
  logic                      udp_send_data_ready = 1'b0;
  logic [DATA_W-1:0]         udp_send_data;
  logic [LEN_W-1:0]          udp_send_data_length;
  logic [2:0]                grant_id;
  logic                      len_err;
  logic                      busy;
`ifdef UDP_TX_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]     pkt_cnt;
  logic [15:0]               drop_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int acc_cnt = 0;
  bit auto_drop = 1'b1;

  logic [DATA_W-1:0] pay  [NUM_REQ];
  logic [LEN_W-1:0]  lens [NUM_REQ];

  always #4 rgmii_clk = ~rgmii_clk;

  udp_tx_arbiter dut (
    .rgmii_clk            (rgmii_clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_data             (req_data),
    .req_len              (req_len),
    .udp_send_data_valid  (udp_send_data_valid),
    .udp_send_data_ready  (udp_send_data_ready),
    .udp_send_data        (udp_send_data),
    .udp_send_data_length (udp_send_data_length),
    .grant_id             (grant_id),
    .len_err              (len_err),
`ifdef UDP_TX_ARB_STATS_EN
    .pkt_cnt              (pkt_cnt),
    .drop_cnt             (drop_cnt),
`endif
    .busy                 (busy)
  );

  // One clock; requesters release valid once they have seen their strobe.
  task automatic tick();
    if (udp_send_data_valid === 1'b1 && udp_send_data_ready === 1'b1) acc_cnt++;
    @(posedge rgmii_clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~req_ready;
  endtask

  task automatic set_inputs();
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_data[i*DATA_W +: DATA_W] = pay[i];
      req_len[i*LEN_W +: LEN_W]    = lens[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (req_ready !== '0) begin n_mis++; $display("FAIL reset/req_ready got %b want 0", req_ready); end
    n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_mis++; $display("FAIL reset/valid got %b want 0", udp_send_data_valid); end
    n_cmp++; if (udp_send_data !== '0) begin n_mis++; $display("FAIL reset/data low64 got %h want 0", udp_send_data[63:0]); end
    n_cmp++; if (udp_send_data_length !== '0) begin n_mis++; $display("FAIL reset/length got %0d want 0", udp_send_data_length); end
    n_cmp++; if (grant_id !== 3'd0) begin n_mis++; $display("FAIL reset/grant_id got %0d want 0", grant_id); end
    n_cmp++; if (len_err !== 1'b0) begin n_mis++; $display("FAIL reset/len_err got %b want 0", len_err); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset/busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int  n;
    bit  vlow;
    lens[0] = 16'd64;
    set_inputs();
    udp_send_data_ready = 1'b1;
    req_valid = 4'b0001;
    n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_mis++; $display("FAIL single/pre_valid got %b want 0", udp_send_data_valid); end
    tick();
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL single/req_ready got %b want 0001", req_ready); end
    n_cmp++; if (udp_send_data_valid !== 1'b1) begin n_mis++; $display("FAIL single/valid got %b want 1", udp_send_data_valid); end
    n_cmp++; if (udp_send_data !== pay[0]) begin n_mis++; $display("FAIL single/data low64 got %h want %h", udp_send_data[63:0], pay[0][63:0]); end
    n_cmp++; if (udp_send_data_length !== 16'd64) begin n_mis++; $display("FAIL single/length got %0d want 64", udp_send_data_length); end
    n_cmp++; if (grant_id !== 3'd0) begin n_mis++; $display("FAIL single/grant_id got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL single/busy got %b want 1", busy); end
    tick();
    n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_mis++; $display("FAIL single/valid_drop got %b want 0", udp_send_data_valid); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_mis++; $display("FAIL single/ready_pulse got %b want 0000", req_ready); end
    n = 0;
    vlow = 1'b1;
    while (busy === 1'b1 && n < 50) begin
      if (udp_send_data_valid !== 1'b0) vlow = 1'b0;
      n++;
      tick();
    end
    n_cmp++; if (n != int'(GAP)) begin n_mis++; $display("FAIL single/gap_cycles got %0d want %0d", n, GAP); end
    n_cmp++; if (vlow !== 1'b1) begin n_mis++; $display("FAIL single/valid_in_gap got %b want 1", vlow); end
    n_cmp++; if (grant_id !== 3'd0) begin n_mis++; $display("FAIL single/grant_after got %0d want 0", grant_id); end
  endtask

  task automatic test_backpressure();
    int acc0;
    lens[1] = 16'd100;
    set_inputs();
    udp_send_data_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    n_cmp++; if (grant_id !== 3'd1) begin n_mis++; $display("FAIL bp/grant_id got %0d want 1", grant_id); end
    acc0 = acc_cnt;
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (udp_send_data_valid !== 1'b1 || udp_send_data !== pay[1] || udp_send_data_length !== 16'd100) begin
        n_mis++;
        $display("FAIL bp/hold cycle %0d got valid=%b len=%0d want valid=1 len=100", c, udp_send_data_valid, udp_send_data_length);
      end
      tick();
    end
    udp_send_data_ready = 1'b1;
    tick();
    n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_mis++; $display("FAIL bp/valid_drop got %b want 0", udp_send_data_valid); end
    for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL bp/idle_timeout got busy=%b want 0", busy); end
    n_cmp++; if (acc_cnt - acc0 != 1) begin n_mis++; $display("FAIL bp/accept_count got %0d want 1", acc_cnt - acc0); end
  endtask

  task automatic test_fairness();
    int         n_rise;
    int         gap;
    logic       prev;
    logic [2:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    lens[0] = 16'd10; lens[1] = 16'd20; lens[2] = 16'd30; lens[3] = 16'd40;
    set_inputs();
    auto_drop = 1'b0;
    udp_send_data_ready = 1'b1;
    req_valid = 4'b1111;
    n_rise = 0;
    gap = 0;
    prev = 1'b0;
    for (int c = 0; c < 400 && n_rise < 8; c++) begin
      tick();
      if (udp_send_data_valid === 1'b1 && prev === 1'b0) begin
        exp_g = 3'(n_rise % 4);
        n_cmp++; if (grant_id !== exp_g) begin n_mis++; $display("FAIL fair/grant %0d got %0d want %0d", n_rise, grant_id, exp_g); end
        n_cmp++; if (req_ready !== (4'b0001 << exp_g)) begin n_mis++; $display("FAIL fair/req_ready %0d got %b want %b", n_rise, req_ready, 4'b0001 << exp_g); end
        n_cmp++; if (udp_send_data_length !== lens[exp_g[1:0]]) begin n_mis++; $display("FAIL fair/length %0d got %0d want %0d", n_rise, udp_send_data_length, lens[exp_g[1:0]]); end
        if (n_rise > 0) begin
          n_cmp++; if (gap != int'(GAP)) begin n_mis++; $display("FAIL fair/gap %0d got %0d want %0d", n_rise, gap, GAP); end
        end
        gap = 0;
        n_rise++;
      end else if (busy === 1'b1 && udp_send_data_valid === 1'b0) begin
        gap++;
      end
      prev = udp_send_data_valid;
    end
    n_cmp++; if (n_rise != 8) begin n_mis++; $display("FAIL fair/packet_count got %0d want 8", n_rise); end
    req_valid = '0;
    auto_drop = 1'b1;
    for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL fair/idle_timeout got busy=%b want 0", busy); end
  endtask

  task automatic test_illegal_len();
    int n_err;
    int n_v;
    bit seen;
    lens[0] = 16'd0;
    lens[1] = 16'd121;
    set_inputs();
    req_valid = 4'b0011;
    n_err = 0;
    n_v = 0;
    tick();
    n_cmp++; if (len_err !== 1'b1) begin n_mis++; $display("FAIL illegal/len_err0 got %b want 1", len_err); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL illegal/ready0 got %b want 0001", req_ready); end
    n_cmp++; if (grant_id !== 3'd0) begin n_mis++; $display("FAIL illegal/grant0 got %0d want 0", grant_id); end
    if (len_err === 1'b1) n_err++;
    if (udp_send_data_valid !== 1'b0) n_v++;
    tick();
    n_cmp++; if (len_err !== 1'b1) begin n_mis++; $display("FAIL illegal/len_err1 got %b want 1", len_err); end
    n_cmp++; if (grant_id !== 3'd1) begin n_mis++; $display("FAIL illegal/grant1 got %0d want 1", grant_id); end
    if (len_err === 1'b1) n_err++;
    if (udp_send_data_valid !== 1'b0) n_v++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (len_err === 1'b1) n_err++;
      if (udp_send_data_valid !== 1'b0) n_v++;
    end
    n_cmp++; if (n_err != 2) begin n_mis++; $display("FAIL illegal/err_pulses got %0d want 2", n_err); end
    n_cmp++; if (n_v != 0) begin n_mis++; $display("FAIL illegal/valid_cycles got %0d want 0", n_v); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL illegal/busy got %b want 0", busy); end
    n_cmp++; if (udp_send_data_length !== 16'd40 || udp_send_data !== pay[3]) begin n_mis++; $display("FAIL illegal/held_outputs got len=%0d want 40", udp_send_data_length); end
    // Pointer sits at 2, so requester 2 beats requester 0.
    lens[0] = 16'd50;
    lens[2] = 16'd120;
    set_inputs();
    req_valid = 4'b0101;
    tick();
    n_cmp++; if (grant_id !== 3'd2) begin n_mis++; $display("FAIL illegal/max_grant got %0d want 2", grant_id); end
    n_cmp++; if (udp_send_data_valid !== 1'b1) begin n_mis++; $display("FAIL illegal/max_valid got %b want 1", udp_send_data_valid); end
    n_cmp++; if (udp_send_data_length !== 16'd120 || udp_send_data !== pay[2]) begin n_mis++; $display("FAIL illegal/max_payload got len=%0d want 120", udp_send_data_length); end
    n_cmp++; if (len_err !== 1'b0) begin n_mis++; $display("FAIL illegal/max_len_err got %b want 0", len_err); end
    tick();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (udp_send_data_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1 || grant_id !== 3'd0 || udp_send_data_length !== 16'd50) begin n_mis++; $display("FAIL illegal/next_grant got seen=%b id=%0d len=%0d want 1/0/50", seen, grant_id, udp_send_data_length); end
    for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL illegal/idle_timeout got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_send();
    lens[1] = 16'd77;
    set_inputs();
    udp_send_data_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    n_cmp++; if (udp_send_data_valid !== 1'b1 || grant_id !== 3'd1) begin n_mis++; $display("FAIL rst_send/pre got valid=%b id=%0d want 1/1", udp_send_data_valid, grant_id); end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (udp_send_data_valid !== 1'b0) begin n_mis++; $display("FAIL rst_send/valid got %b want 0", udp_send_data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_send/busy got %b want 0", busy); end
    n_cmp++; if (udp_send_data_length !== '0 || grant_id !== 3'd0) begin n_mis++; $display("FAIL rst_send/cleared got len=%0d id=%0d want 0/0", udp_send_data_length, grant_id); end
    rst = 1'b0;
    udp_send_data_ready = 1'b1;
    req_valid = 4'b1001;
    tick();
    n_cmp++; if (grant_id !== 3'd0 || udp_send_data_valid !== 1'b1) begin n_mis++; $display("FAIL rst_send/next_grant got id=%0d valid=%b want 0/1", grant_id, udp_send_data_valid); end
    n_cmp++; if (req_ready !== 4'b0001) begin n_mis++; $display("FAIL rst_send/next_ready got %b want 0001", req_ready); end
    req_valid = '0;
    for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_send/idle_timeout got busy=%b want 0", busy); end
  endtask

`ifdef UDP_TX_ARB_STATS_EN
  task automatic test_stats();
    rst = 1'b1; tick(); rst = 1'b0; tick();
    udp_send_data_ready = 1'b1;
    lens[1] = 16'd30;
    set_inputs();
    for (int p = 0; p < 3; p++) begin
      req_valid = 4'b0010;
      tick();
      for (int n = 0; n < 50 && busy === 1'b1; n++) tick();
    end
    lens[1] = 16'd0;
    set_inputs();
    req_valid = 4'b0010;
    tick(); tick();
    n_cmp++; if (pkt_cnt[31:16] !== 16'd3) begin n_mis++; $display("FAIL stats/pkt_cnt1 got %0d want 3", pkt_cnt[31:16]); end
    n_cmp++; if (pkt_cnt[15:0] !== 16'd0) begin n_mis++; $display("FAIL stats/pkt_cnt0 got %0d want 0", pkt_cnt[15:0]); end
    n_cmp++; if (drop_cnt !== 16'd1) begin n_mis++; $display("FAIL stats/drop_cnt got %0d want 1", drop_cnt); end
  endtask
`endif

  initial begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      logic [31:0] w;
      w = 32'hA5C3_1000 + 32'(i * 32'h0101_0101);
      pay[i]  = DATA_W'({31{w}});
      lens[i] = 16'd1;
    end
    set_inputs();
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_fairness();
    test_illegal_len();
    test_reset_mid_send();
`ifdef UDP_TX_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
